bldc_commutator: RTL and testbench

Parametrised six-step BLDC commutation engine for the motor board. It takes raw hall inputs and produces the six half-bridge gate drives (INH*/INL*) from a PWM carrier, direction and enable. Compared with the inline commutation logic, it adds:
- hall synchronisation and glitch filtering
- runtime-programmable dead time
- invalid-hall and skipped-step detection
- a signed commutation step counter
- latched driver-fault shutdown
It sits between the hall SB_IO inputs / pwm module and the INHx/INLx pins.

---
 rtl/bldc_commutator.sv | 220 ++++++++++++++++++++++
 tb/tb_bldc_commutator.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutation engine: hall sync/filter, sector tracking with step counting,
// dead-time sequencing and latched driver-fault shutdown in front of the INHx/INLx pins.
module bldc_commutator #(
    parameter int HALL_FILTER = 16,
    parameter int DT_W        = 10,
    parameter int STEP_W      = 24
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [2:0]        hall,
    input  logic              pwm_in,
    input  logic              dir,
    input  logic              enable,
    input  logic [DT_W-1:0]   dead_time,
    input  logic              fault_n,
    input  logic              clear_fault,
    output logic [2:0]        INH,
    output logic [2:0]        INL,
    output logic [2:0]        comm_state,
    output logic [STEP_W-1:0] step_count,
    output logic              hall_error,
    output logic              skip_error,
    output logic              fault_latched
);

    localparam int              FC_W   = $clog2(HALL_FILTER + 1);
    localparam logic [FC_W-1:0] FC_MAX = FC_W'(HALL_FILTER);

    localparam logic [1:0] ST_OFF      = 2'd0;
    localparam logic [1:0] ST_DEADTIME = 2'd1;
    localparam logic [1:0] ST_DRIVE    = 2'd2;
    localparam logic [1:0] ST_FAULT    = 2'd3;

    // Returns {valid, index}; 000 and 111 are the impossible hall codes.
    function automatic logic [3:0] decode_hall(input logic [2:0] code);
        case (code)
            3'b101:  return 4'b1_000;
            3'b100:  return 4'b1_001;
            3'b110:  return 4'b1_010;
            3'b010:  return 4'b1_011;
            3'b011:  return 4'b1_100;
            3'b001:  return 4'b1_101;
            default: return 4'b0_000;
        endcase
    endfunction

    // {gh[A,B,C], gl[A,B,C]}; the reverse table is the forward table shifted by three sectors.
    function automatic logic [5:0] sector_pattern(input logic [2:0] idx, input logic fwd);
        logic [2:0] k;
        k = fwd ? idx : ((idx >= 3'd3) ? idx - 3'd3 : idx + 3'd3);
        case (k)
            3'd0:    return 6'b001_010;
            3'd1:    return 6'b100_010;
            3'd2:    return 6'b100_001;
            3'd3:    return 6'b010_001;
            3'd4:    return 6'b010_100;
            3'd5:    return 6'b001_100;
            default: return 6'b000_000;
        endcase
    endfunction

    logic [2:0]        hall_s1_q, hall_s1_d, hall_s2_q, hall_s2_d;
    logic              fault_s1_q, fault_s1_d, fault_s2_q, fault_s2_d;
    logic [2:0]        hall_prev_q, hall_prev_d, hall_acc_q, hall_acc_d;
    logic [FC_W-1:0]   filt_cnt_q, filt_cnt_d;
    logic              acc_new_q, acc_new_d;
    logic [2:0]        comm_state_q, comm_state_d;
    logic              sector_valid_q, sector_valid_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              hall_err_q, hall_err_d, skip_err_q, skip_err_d;
    logic [1:0]        state_q, state_d;
    logic [5:0]        pat_q, pat_d;
    logic [DT_W-1:0]   dt_cnt_q, dt_cnt_d, dt_q, dt_d;
    logic [2:0]        inh_q, inh_d, inl_q, inl_d;

    logic [3:0]        sector;
    logic [2:0]        succ, pred;
    logic [5:0]        target, gates;
    logic [DT_W:0]     dt_next;
    logic              dt_done;

    always_comb begin
        hall_s1_d   = hall;
        hall_s2_d   = hall_s1_q;
        fault_s1_d  = fault_n;
        fault_s2_d  = fault_s1_q;
        hall_prev_d = hall_s2_q;

        if (hall_s2_q != hall_prev_q)  filt_cnt_d = FC_W'(1);
        else if (filt_cnt_q == FC_MAX) filt_cnt_d = filt_cnt_q;
        else                           filt_cnt_d = filt_cnt_q + FC_W'(1);
        acc_new_d  = (filt_cnt_d == FC_MAX) && (hall_s2_q != hall_acc_q);
        hall_acc_d = acc_new_d ? hall_s2_q : hall_acc_q;

        sector         = decode_hall(hall_acc_q);
        succ           = (comm_state_q == 3'd5) ? 3'd0 : comm_state_q + 3'd1;
        pred           = (comm_state_q == 3'd0) ? 3'd5 : comm_state_q - 3'd1;
        comm_state_d   = comm_state_q;
        sector_valid_d = sector_valid_q;
        step_d         = step_q;
        hall_err_d     = 1'b0;
        skip_err_d     = 1'b0;
        if (acc_new_q) begin
            if (sector[3]) begin
                comm_state_d   = sector[2:0];
                sector_valid_d = 1'b1;
                // The first valid sector after an invalid one has no reference to step from.
                if (sector_valid_q) begin
                    if (sector[2:0] == succ)      step_d = step_q + STEP_W'(1);
                    else if (sector[2:0] == pred) step_d = step_q - STEP_W'(1);
                    else                          skip_err_d = 1'b1;
                end
            end else begin
                hall_err_d     = 1'b1;
                sector_valid_d = 1'b0;
            end
        end

        target  = (enable && sector_valid_q && state_q != ST_FAULT)
                  ? sector_pattern(comm_state_q, dir) : 6'b0;
        dt_next = {1'b0, dt_cnt_q} + (DT_W + 1)'(1);
        dt_done = dt_next >= {1'b0, dt_q};
        state_d  = state_q;
        pat_d    = pat_q;
        dt_cnt_d = dt_cnt_q;
        dt_d     = dt_q;
        case (state_q)
            ST_OFF: begin
                if (target != 6'b0) begin
                    state_d  = ST_DEADTIME;
                    pat_d    = target;
                    dt_cnt_d = '0;
                    dt_d     = dead_time;
                end
            end
            ST_DEADTIME: begin
                if (target != pat_q) begin
                    state_d  = (target == 6'b0) ? ST_OFF : ST_DEADTIME;
                    pat_d    = target;
                    dt_cnt_d = '0;
                end else if (dt_done) begin
                    state_d = ST_DRIVE;
                end else begin
                    dt_cnt_d = dt_next[DT_W-1:0];
                end
            end
            ST_DRIVE: begin
                if (target != pat_q) begin
                    state_d  = (target == 6'b0) ? ST_OFF : ST_DEADTIME;
                    pat_d    = target;
                    dt_cnt_d = '0;
                    dt_d     = dead_time;
                end
            end
            default: begin
                if (clear_fault && fault_s2_q) state_d = ST_OFF;
            end
        endcase
        if (!fault_s2_q) state_d = ST_FAULT;

        // NOTE: gates are also masked by the synchronised fault so they drop in the cycle FAULT is entered.
        gates = (state_q == ST_DRIVE && fault_s2_q) ? pat_q : 6'b0;
        inh_d = gates[5:3] & {3{pwm_in}};
        inl_d = gates[2:0];
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            hall_s1_q      <= 3'b0;
            hall_s2_q      <= 3'b0;
            // NOTE: fault synchronisers reset to the inactive level so reset release does not trip FAULT.
            fault_s1_q     <= 1'b1;
            fault_s2_q     <= 1'b1;
            hall_prev_q    <= 3'b0;
            hall_acc_q     <= 3'b0;
            filt_cnt_q     <= '0;
            acc_new_q      <= 1'b0;
            comm_state_q   <= 3'd0;
            sector_valid_q <= 1'b0;
            step_q         <= '0;
            hall_err_q     <= 1'b0;
            skip_err_q     <= 1'b0;
            state_q        <= ST_OFF;
            pat_q          <= 6'b0;
            dt_cnt_q       <= '0;
            dt_q           <= '0;
            inh_q          <= 3'b0;
            inl_q          <= 3'b0;
        end else begin
            hall_s1_q      <= hall_s1_d;
            hall_s2_q      <= hall_s2_d;
            fault_s1_q     <= fault_s1_d;
            fault_s2_q     <= fault_s2_d;
            hall_prev_q    <= hall_prev_d;
            hall_acc_q     <= hall_acc_d;
            filt_cnt_q     <= filt_cnt_d;
            acc_new_q      <= acc_new_d;
            comm_state_q   <= comm_state_d;
            sector_valid_q <= sector_valid_d;
            step_q         <= step_d;
            hall_err_q     <= hall_err_d;
            skip_err_q     <= skip_err_d;
            state_q        <= state_d;
            pat_q          <= pat_d;
            dt_cnt_q       <= dt_cnt_d;
            dt_q           <= dt_d;
            inh_q          <= inh_d;
            inl_q          <= inl_d;
        end
    end

    assign INH           = inh_q;
    assign INL           = inl_q;
    assign comm_state    = comm_state_q;
    assign step_count    = step_q;
    assign hall_error    = hall_err_q;
    assign skip_error    = skip_err_q;
    assign fault_latched = (state_q == ST_FAULT);

endmodule

// File: tb/tb_bldc_commutator.sv
// Directed bench for bldc_commutator: hall sequencing, filtering, dead time, fault handling and reset.
module tb_bldc_commutator;

    logic        CLK = 1'b0;
    logic        reset;
    logic [2:0]  hall;
    logic        pwm_in, dir, enable, fault_n, clear_fault;
    logic [9:0]  dead_time;
    logic [2:0]  INH, INL, comm_state;
    logic [23:0] step_count;
    logic        hall_error, skip_error, fault_latched;

    int checks = 0;
    int errors = 0;
    int off_cnt = 0, herr_cnt = 0, skip_cnt = 0;
    int off_base, herr_base, skip_base;

    bldc_commutator #(.HALL_FILTER(16), .DT_W(10), .STEP_W(24)) dut (
        .CLK(CLK), .reset(reset), .hall(hall), .pwm_in(pwm_in), .dir(dir),
        .enable(enable), .dead_time(dead_time), .fault_n(fault_n),
        .clear_fault(clear_fault), .INH(INH), .INL(INL), .comm_state(comm_state),
        .step_count(step_count), .hall_error(hall_error), .skip_error(skip_error),
        .fault_latched(fault_latched)
    );

    always #5 CLK = ~CLK;

    // Pulse and all-off counters, sampled on the inactive edge.
    always @(negedge CLK) begin
        if (hall_error) herr_cnt++;
        if (skip_error) skip_cnt++;
        if (INH == 3'b0 && INL == 3'b0) off_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [2:0] fwd_code[6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
    logic [2:0] fwd_idx [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    logic [2:0] fwd_inh [6] = '{3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b001};
    logic [2:0] fwd_inl [6] = '{3'b010, 3'b001, 3'b001, 3'b100, 3'b100, 3'b010};
    logic [2:0] rev_code[6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
    logic [2:0] rev_idx [6] = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    logic [2:0] rev_inh [6] = '{3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
    logic [2:0] rev_inl [6] = '{3'b100, 3'b100, 3'b001, 3'b001, 3'b010, 3'b010};

    initial begin
        reset = 1'b0; hall = 3'b000; pwm_in = 1'b1; dir = 1'b1; enable = 1'b0;
        dead_time = 10'd4; fault_n = 1'b1; clear_fault = 1'b0;
        tick(3);
        check("rst_inh", INH, 3'b000);
        check("rst_inl", INL, 3'b000);
        check("rst_comm", comm_state, 3'd0);
        check("rst_step", step_count, 24'd0);
        check("rst_fault", fault_latched, 1'b0);
        check("rst_herr", hall_error, 1'b0);

        // First drive: 2 + 16 + 1 + 1 + 4 + 1 = 25 cycles from hall edge to gates
        hall = 3'b101; enable = 1'b1; reset = 1'b1;
        tick(24);
        check("t1_pre_inh", INH, 3'b000);
        tick(1);
        check("t1_inh", INH, 3'b001);
        check("t1_inl", INL, 3'b010);
        check("t1_step", step_count, 24'd0);
        check("t1_comm", comm_state, 3'd0);

        herr_base = herr_cnt; skip_base = skip_cnt;
        for (int i = 0; i < 6; i++) begin
            hall = fwd_code[i]; off_base = off_cnt;
            tick(100);
            check($sformatf("t2_off_%0d", i), off_cnt - off_base, 4);
            check($sformatf("t2_comm_%0d", i), comm_state, fwd_idx[i]);
            check($sformatf("t2_inh_%0d", i), INH, fwd_inh[i]);
            check($sformatf("t2_inl_%0d", i), INL, fwd_inl[i]);
        end
        check("t2_step", 32'($signed(step_count)), 6);
        check("t2_herr", herr_cnt - herr_base, 0);
        check("t2_skip", skip_cnt - skip_base, 0);

        reset = 1'b0; tick(2); reset = 1'b1;
        tick(40);
        check("t3_start_inh", INH, 3'b001);
        for (int i = 0; i < 6; i++) begin
            hall = rev_code[i];
            tick(100);
            check($sformatf("t3_comm_%0d", i), comm_state, rev_idx[i]);
            check($sformatf("t3_inh_%0d", i), INH, rev_inh[i]);
            check($sformatf("t3_inl_%0d", i), INL, rev_inl[i]);
        end
        check("t3_step", 32'($signed(step_count)), -6);
        skip_base = skip_cnt;
        hall = 3'b010;
        tick(100);
        check("t3_skip", skip_cnt - skip_base, 1);
        check("t3_skip_step", 32'($signed(step_count)), -6);
        check("t3_skip_comm", comm_state, 3'd3);
        check("t3_skip_inh", INH, 3'b010);
        check("t3_skip_inl", INL, 3'b001);

        herr_base = herr_cnt; off_base = off_cnt; skip_base = skip_cnt;
        hall = 3'b111; tick(5); hall = 3'b010;
        tick(100);
        check("t4_glitch_comm", comm_state, 3'd3);
        check("t4_glitch_herr", herr_cnt - herr_base, 0);
        check("t4_glitch_off", off_cnt - off_base, 0);
        check("t4_glitch_inh", INH, 3'b010);
        hall = 3'b111;
        tick(20);
        check("t4_herr", herr_cnt - herr_base, 1);
        check("t4_comm_hold", comm_state, 3'd3);
        tick(2);
        check("t4_off_inh", INH, 3'b000);
        check("t4_off_inl", INL, 3'b000);
        hall = 3'b101;
        tick(24);
        check("t4_resume_pre", INH, 3'b000);
        tick(1);
        check("t4_resume_inh", INH, 3'b001);
        check("t4_resume_inl", INL, 3'b010);
        check("t4_step", 32'($signed(step_count)), -6);
        check("t4_skip", skip_cnt - skip_base, 0);
        check("t4_comm", comm_state, 3'd0);

        fault_n = 1'b0;
        tick(3);
        check("t5_fault_inh", INH, 3'b000);
        check("t5_fault_inl", INL, 3'b000);
        check("t5_fault_lat", fault_latched, 1'b1);
        clear_fault = 1'b1; tick(1); clear_fault = 1'b0;
        tick(4);
        check("t5_ign_lat", fault_latched, 1'b1);
        check("t5_ign_inl", INL, 3'b000);
        fault_n = 1'b1;
        tick(4);
        check("t5_noclr_lat", fault_latched, 1'b1);
        clear_fault = 1'b1; tick(1); clear_fault = 1'b0;
        check("t5_clr_lat", fault_latched, 1'b0);
        tick(5);
        check("t5_dt_inh", INH, 3'b000);
        tick(1);
        check("t5_drive_inh", INH, 3'b001);
        check("t5_drive_inl", INL, 3'b010);

        pwm_in = 1'b0;
        tick(1);
        check("t6_pwm_inh", INH, 3'b000);
        check("t6_pwm_inl", INL, 3'b010);
        pwm_in = 1'b1;
        tick(1);
        check("t6_pwm_back", INH, 3'b001);
        dead_time = 10'd0; off_base = off_cnt; dir = 1'b0;
        tick(3);
        check("t6_rev_inh", INH, 3'b010);
        check("t6_rev_inl", INL, 3'b001);
        tick(10);
        check("t6_rev_off", off_cnt - off_base, 1);
        dead_time = 10'd50; dir = 1'b1;
        tick(5);
        check("t6_dt_inh", INH, 3'b000);
        reset = 1'b0;
        tick(1);
        check("t6_rst_inh", INH, 3'b000);
        check("t6_rst_inl", INL, 3'b000);
        check("t6_rst_comm", comm_state, 3'd0);
        check("t6_rst_step", step_count, 24'd0);
        check("t6_rst_fault", fault_latched, 1'b0);
        check("t6_rst_skip", skip_error, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
